// File: rtl/ysyx_22040575_lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package ysyx_22040575_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/ysyx_22040575_lsu_if.sv
// Execute-side request, data-memory bus and writeback response of the LSU.
interface ysyx_22040575_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_rd_addr;
  logic                  busy;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_rd_wen;
  logic [4:0]            rsp_rd_addr;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // LSU side
  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, req_rd_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, busy,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output rsp_valid, rsp_rd_wen, rsp_rd_addr, rsp_rdata, rsp_err
  );

  // Pipeline / memory environment side
  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata, req_rd_addr,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, busy,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  rsp_valid, rsp_rd_wen, rsp_rd_addr, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ysyx_22040575_lsu_align.sv
// Byte-lane steering for the LSU: store replication/strobes, load extraction
// with sign/zero extension, and alignment checking of an incoming request.
module ysyx_22040575_lsu_align
  import ysyx_22040575_lsu_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr_lo,
  output logic        chk_misaligned,

  input  logic        wen,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] ld_data
);

  logic [3:0]  strb;
  logic [15:0] lane_lo;

  always_comb begin
    case (chk_size)
      SZ_B:    chk_misaligned = 1'b0;
      SZ_H:    chk_misaligned = chk_addr_lo[0];
      SZ_W:    chk_misaligned = (chk_addr_lo != 2'b00);
      default: chk_misaligned = 1'b1;
    endcase
  end

  // Every lane carries a copy so the memory only needs to honour the strobes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign st_wdata[8*gi +: 8] = (size == SZ_B) ? wdata[7:0] :
                                   (size == SZ_H) ? wdata[8*(gi%2) +: 8] :
                                                    wdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (size)
      SZ_B:    strb = STRB_B << addr_lo;
      SZ_H:    strb = STRB_H << addr_lo;
      default: strb = STRB_W;
    endcase
    st_wstrb = wen ? strb : STRB_NONE;
  end

  assign lane_lo = 16'(rdata >> {addr_lo, 3'b000});

  always_comb begin
    case (size)
      SZ_B:    ld_data = {{24{lane_lo[7]  & ~is_unsigned}}, lane_lo[7:0]};
      SZ_H:    ld_data = {{16{lane_lo[15] & ~is_unsigned}}, lane_lo};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_22040575_lsu.sv
// Single-outstanding load/store unit: request capture, memory handshake FSM
// and writeback response. All outputs come from state or captured registers.
module ysyx_22040575_lsu
  import ysyx_22040575_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  ysyx_22040575_lsu_if.slave     bus
);

  lsu_state_e            state_q, state_d;
  logic                  wen_q, wen_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  misaligned;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_wstrb;
  logic [DATA_WIDTH-1:0] ld_data;

  ysyx_22040575_lsu_align u_align (
    .chk_size       (bus.req_size),
    .chk_addr_lo    (bus.req_addr[1:0]),
    .chk_misaligned (misaligned),
    .wen            (wen_q),
    .size           (size_q),
    .addr_lo        (addr_q[1:0]),
    .is_unsigned    (uns_q),
    .wdata          (wdata_q),
    .rdata          (bus.mem_rdata),
    .st_wdata       (st_wdata),
    .st_wstrb       (st_wstrb),
    .ld_data        (ld_data)
  );

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wen_d   = bus.req_wen;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rd_d    = bus.req_rd_addr;
          // Bad accesses complete immediately without touching memory.
          if (misaligned) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : ld_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 5'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.mem_req_valid = (state_q == ST_REQ);
  assign bus.mem_wen       = wen_q;
  assign bus.mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata     = st_wdata;
  assign bus.mem_wstrb     = st_wstrb;
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_rd_wen    = (state_q == ST_RESP) & ~wen_q & ~err_q & (rd_q != 5'd0);
  assign bus.rsp_rd_addr   = rd_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;

endmodule

// File: tb/tb_ysyx_22040575_lsu.sv
// Scoreboard bench for the LSU: random and directed accesses against a
// byte-arithmetic reference model, with a scripted memory responder.
module tb_ysyx_22040575_lsu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ysyx_22040575_lsu_if bus ();

  ysyx_22040575_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        rd_wen;
    logic [4:0]  rd;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memx_t;

  typedef struct {
    logic [31:0] rdata;
    int          rdy;
    int          rsp;
  } plan_t;

  rsp_t  exp_rsp[$];
  memx_t exp_mem[$];
  plan_t plan_q[$];

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit inflight = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_tb();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".req_ready"},     32'(bus.req_ready),     32'd1);
    chk({tag, ".busy"},          32'(bus.busy),          32'd0);
    chk({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, ".mem_wen"},       32'(bus.mem_wen),       32'd0);
    chk({tag, ".mem_addr"},      bus.mem_addr,           32'd0);
    chk({tag, ".mem_wdata"},     bus.mem_wdata,          32'd0);
    chk({tag, ".mem_wstrb"},     32'(bus.mem_wstrb),     32'd0);
    chk({tag, ".rsp_valid"},     32'(bus.rsp_valid),     32'd0);
    chk({tag, ".rsp_rd_wen"},    32'(bus.rsp_rd_wen),    32'd0);
    chk({tag, ".rsp_rd_addr"},   32'(bus.rsp_rd_addr),   32'd0);
    chk({tag, ".rsp_rdata"},     bus.rsp_rdata,          32'd0);
    chk({tag, ".rsp_err"},       32'(bus.rsp_err),       32'd0);
  endtask

  // Reference load: shift the word down by the byte offset, mask, then
  // sign-extend by plain two's-complement subtraction.
  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                           input int o, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * o);
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Memory responder: ready after plan.rdy cycles, response plan.rsp cycles later.
  initial begin
    plan_t p;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1 && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        repeat (p.rdy) @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        repeat (p.rsp) @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = p.rdata;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = $urandom;
      end
    end
  end

  // Memory-side monitor: payload checked every cycle the request is up.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset && bus.mem_req_valid === 1'b1) begin
        if (exp_mem.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_mem_req: mem_req_valid=1 required 0 (cycle %0d)", cyc);
        end else begin
          chk("mem_addr",  bus.mem_addr,           exp_mem[0].addr);
          chk("mem_wen",   32'(bus.mem_wen),       32'(exp_mem[0].wen));
          chk("mem_wstrb", 32'(bus.mem_wstrb),     32'(exp_mem[0].wstrb));
          if (exp_mem[0].wen) chk("mem_wdata", bus.mem_wdata, exp_mem[0].wdata);
          if (bus.mem_req_ready) void'(exp_mem.pop_front());
        end
      end
    end
  end

  // Response monitor: busy/ready tracking and completion scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk("busy",      32'(bus.busy),      32'(inflight));
        chk("req_ready", 32'(bus.req_ready), 32'(!inflight));
        if (bus.rsp_valid === 1'b1) begin
          if (exp_rsp.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 required 0 (cycle %0d)", cyc);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_rdata",   bus.rsp_rdata,            e.rdata);
            chk("rsp_err",     32'(bus.rsp_err),         32'(e.err));
            chk("rsp_rd_wen",  32'(bus.rsp_rd_wen),      32'(e.rd_wen));
            chk("rsp_rd_addr", 32'(bus.rsp_rd_addr),     32'(e.rd));
            chk("latency",     32'(cyc - acc_cyc),       32'(e.lat));
            inflight = 1'b0;
          end
        end
      end
    end
  end

  // Called at negedge+2. abort=1 pulls reset while the access sits in WAIT.
  task automatic issue(input bit wen, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] mrd,
                       input int rdy, input int rsp, input bit abort);
    rsp_t  e;
    memx_t m;
    plan_t p;
    int    o;
    int    t;
    bit    err;
    o   = int'(addr & 32'd3);
    err = (size == 2'd3) || (size == 2'd1 && (o % 2) != 0) || (size == 2'd2 && o != 0);
    e.err    = err;
    e.rd     = rd;
    e.rd_wen = !wen && !err && (rd != 5'd0);
    e.rdata  = (wen || err) ? 32'h0 : ref_load(size, uns, o, mrd);
    e.lat    = err ? 1 : 3 + rdy + rsp;
    exp_rsp.push_back(e);
    if (!err) begin
      m.addr = addr & ~32'd3;
      m.wen  = wen;
      if (size == 2'd0)      m.wdata = (wdata & 32'hFF) * 32'h01010101;
      else if (size == 2'd1) m.wdata = (wdata & 32'hFFFF) * 32'h00010001;
      else                   m.wdata = wdata;
      if (!wen)              m.wstrb = 4'h0;
      else if (size == 2'd0) m.wstrb = 4'(1 << o);
      else if (size == 2'd1) m.wstrb = 4'(3 << o);
      else                   m.wstrb = 4'hF;
      exp_mem.push_back(m);
      p.rdata = mrd;
      p.rdy   = rdy;
      p.rsp   = rsp;
      plan_q.push_back(p);
    end
    bus.req_valid    = 1'b1;
    bus.req_wen      = wen;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd_addr  = rd;
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!bus.req_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready=0 required 1 (cycle %0d)", cyc);
      finish_tb();
    end
    acc_cyc = cyc;
    @(posedge clk);
    inflight = 1'b1;
    #1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom_range(0, 3));
    if (abort) begin
      @(negedge clk);
      @(negedge clk);
      #2;
      reset    = 1'b0;
      inflight = 1'b0;
      exp_rsp.delete();
      #1;
      check_idle_outputs("reset_in_wait");
      @(negedge clk);
      #1;
      check_idle_outputs("reset_held");
      #1;
      reset = 1'b1;
      repeat (12) begin
        @(negedge clk);
        #2;
      end
      check_idle_outputs("after_stale_rsp");
    end else begin
      t = 0;
      while (inflight && t < 100) begin
        @(negedge clk);
        #2;
        t++;
      end
      if (inflight) begin
        n_fail++;
        $display("FAIL rsp_timeout: rsp_valid never seen, required 1 (cycle %0d)", cyc);
        finish_tb();
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #2;
      end
    end
  endtask

  initial begin
    bit          r_wen;
    bit          r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          r_sel;
    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_rd_addr  = 5'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    #1;
    reset = 1'b1;
    @(negedge clk);
    #2;

    issue(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,         5'd5, 32'hDEAD_BEEF, 0, 0, 1'b0); // LW
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,         5'd6, 32'h80FF_1234, 0, 0, 1'b0); // LB
    issue(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,         5'd6, 32'h80FF_1234, 0, 0, 1'b0); // LBU
    issue(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 5'd7, 32'h5555_AAAA, 0, 0, 1'b0); // SH
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,         5'd8, 32'h0,         0, 0, 1'b0); // misaligned LW
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         5'd9, 32'hCAFE_F00D, 3, 2, 1'b0); // stall
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0006, 32'h0,         5'd0, 32'h8001_7FFF, 0, 0, 1'b0); // LH to x0
    issue(1'b1, 2'd3, 1'b0, 32'h8000_0000, 32'h0,         5'd3, 32'h0,         0, 0, 1'b0); // illegal size
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0,        5'd10, 32'h1234_5678, 0, 6, 1'b1); // reset in WAIT
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0024, 32'h0,        5'd11, 32'h0BAD_F00D, 0, 0, 1'b0); // after reset

    for (int i = 0; i < 250; i++) begin
      r_sel  = $urandom_range(0, 9);
      r_size = (r_sel < 3) ? 2'd0 : (r_sel < 6) ? 2'd1 : (r_sel < 9) ? 2'd2 : 2'd3;
      r_wen  = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (r_size == 2'd1) r_addr = r_addr & ~32'd1;
        if (r_size == 2'd2) r_addr = r_addr & ~32'd3;
      end
      issue(r_wen, r_size, r_uns, r_addr, $urandom, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    repeat (4) @(negedge clk);
    if (exp_rsp.size() != 0 || exp_mem.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: rsp=%0d mem=%0d required 0", exp_rsp.size(), exp_mem.size());
    end
    n_vec++;
    finish_tb();
  end

endmodule
